dt_scan_ctrl: RTL and testbench

//  Sequencer for the two-pass distance-transform datapath. Runs a forward raster

---
 rtl/dt_pkg.sv | 20 ++
 rtl/dt_idx_counter.sv | 74 +++++++
 rtl/dt_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_dt_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared constants and the scan-state type for the two-pass distance-transform sequencer.
package dt_pkg;

  localparam int IMG_W    = 128;
  localparam int IMG_H    = 128;
  localparam int STI_W    = 16;
  localparam int RES_AW   = $clog2(IMG_W * IMG_H);
  localparam int STI_AW   = RES_AW - $clog2(STI_W);
  localparam int LAST_IDX = IMG_W * IMG_H - 1;
  localparam int COL_MSB  = $clog2(IMG_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    BRD,
    BWR,
    DONE
  } scan_state_t;

endpackage

// File: rtl/dt_idx_counter.sv
// Pixel index with separate row/column trackers; exposes next-state values so the
// sequencer can register outputs that line up with the address it drives.
module dt_idx_counter #(
  parameter int IMG_W  = dt_pkg::IMG_W,
  parameter int IMG_H  = dt_pkg::IMG_H,
  parameter int RES_AW = dt_pkg::RES_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              down,
  output logic [RES_AW-1:0] idx_nxt,
  output logic              is_last,
  output logic              is_first,
  output logic              on_border
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [RES_AW-1:0] LAST    = RES_AW'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(IMG_H - 1);

  logic [RES_AW-1:0] idx_q;
  logic [COL_W-1:0]  col_q, col_nxt;
  logic [ROW_W-1:0]  row_q, row_nxt;

  // Row/column follow the index by wrap detection rather than a divide.
  always_comb begin
    idx_nxt = idx_q;
    col_nxt = col_q;
    row_nxt = row_q;
    if (load) begin
      idx_nxt = '0;
      col_nxt = '0;
      row_nxt = '0;
    end else if (step && down) begin
      idx_nxt = idx_q - RES_AW'(1);
      if (col_q == '0) begin
        col_nxt = COL_MAX;
        row_nxt = row_q - ROW_W'(1);
      end else begin
        col_nxt = col_q - COL_W'(1);
      end
    end else if (step) begin
      idx_nxt = idx_q + RES_AW'(1);
      if (col_q == COL_MAX) begin
        col_nxt = '0;
        row_nxt = row_q + ROW_W'(1);
      end else begin
        col_nxt = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      idx_q <= idx_nxt;
      col_q <= col_nxt;
      row_q <= row_nxt;
    end
  end

  assign is_last   = (idx_q == LAST);
  assign is_first  = (idx_q == '0);
  assign on_border = (row_nxt == '0) || (row_nxt == ROW_MAX) ||
                     (col_nxt == '0) || (col_nxt == COL_MAX);

endmodule

// File: rtl/dt_scan_ctrl.sv
// Forward-then-backward raster sequencer for the distance-transform datapath.
// Every output is registered from next-state values so it aligns with res_addr.
module dt_scan_ctrl
  import dt_pkg::*;
#(
  parameter int IMG_W  = dt_pkg::IMG_W,
  parameter int IMG_H  = dt_pkg::IMG_H,
  parameter int STI_W  = dt_pkg::STI_W,
  parameter int RES_AW = dt_pkg::RES_AW,
  parameter int STI_AW = dt_pkg::STI_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  output logic [3:0]        bit_sel,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic              pass,
  output logic              border,
  output logic              pix_valid,
  input  logic              pix_ready
);

  localparam int         STI_SH  = $clog2(STI_W);
  localparam logic [3:0] BIT_MAX = 4'(STI_W - 1);

  scan_state_t state_q, state_d;

  logic              load, step, down;
  logic              is_last, is_first, on_border, in_pass;
  logic [RES_AW-1:0] idx_nxt;

  logic              busy_d, done_d, sti_rd_d, res_rd_d, res_wr_d;
  logic              pass_d, border_d, pix_valid_d;
  logic [STI_AW-1:0] sti_addr_d;
  logic [3:0]        bit_sel_d;
  logic [RES_AW-1:0] res_addr_d;

  dt_idx_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .RES_AW (RES_AW)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .down      (down),
    .idx_nxt   (idx_nxt),
    .is_last   (is_last),
    .is_first  (is_first),
    .on_border (on_border)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sti_rd    <= 1'b0;
      sti_addr  <= '0;
      bit_sel   <= '0;
      res_rd    <= 1'b0;
      res_wr    <= 1'b0;
      res_addr  <= '0;
      pass      <= 1'b0;
      border    <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      sti_rd    <= sti_rd_d;
      sti_addr  <= sti_addr_d;
      bit_sel   <= bit_sel_d;
      res_rd    <= res_rd_d;
      res_wr    <= res_wr_d;
      res_addr  <= res_addr_d;
      pass      <= pass_d;
      border    <= border_d;
      pix_valid <= pix_valid_d;
    end
  end

  // The last forward pixel hands over to the backward pass without moving idx.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    down    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FWD;
          load    = 1'b1;
        end
      end
      FWD: begin
        if (pix_ready) begin
          if (is_last) state_d = BRD;
          else         step    = 1'b1;
        end
      end
      BRD: state_d = BWR;
      BWR: begin
        down = 1'b1;
        if (pix_ready) begin
          if (is_first) begin
            state_d = DONE;
          end else begin
            step    = 1'b1;
            state_d = BRD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_pass     = (state_d == FWD) || (state_d == BRD) || (state_d == BWR);
    busy_d      = in_pass;
    done_d      = (state_d == DONE);
    sti_rd_d    = in_pass;
    res_rd_d    = (state_d == BRD);
    res_wr_d    = (state_d == FWD) || (state_d == BWR);
    pix_valid_d = res_wr_d;
    pass_d      = (state_d == BRD) || (state_d == BWR);
    border_d    = in_pass && on_border;
    res_addr_d  = in_pass ? idx_nxt : '0;
    sti_addr_d  = in_pass ? STI_AW'(idx_nxt >> STI_SH) : '0;
    bit_sel_d   = in_pass ? (BIT_MAX - 4'(idx_nxt[STI_SH-1:0])) : '0;
  end

endmodule

// File: tb/tb_dt_scan_ctrl.sv
// Randomized bench for dt_scan_ctrl: a pixel-position model predicts every output
// each cycle, with a few literal address/border/timing points pinning that model.
module tb_dt_scan_ctrl;

  localparam int W    = 128;
  localparam int H    = 128;
  localparam int NPIX = W * H;

  logic        clk, reset, start, pix_ready;
  logic        busy, done, sti_rd, res_rd, res_wr, pass, border, pix_valid;
  logic [9:0]  sti_addr;
  logic [3:0]  bit_sel;
  logic [13:0] res_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: job active, backward pass, waiting-for-read cycle, finished, pixel position.
  bit m_active = 0, m_back = 0, m_rdcyc = 0, m_done = 0;
  int m_pix = 0;
  int e_row, e_col;

  dt_scan_ctrl #(
    .IMG_W (W), .IMG_H (H), .STI_W (16), .RES_AW (14), .STI_AW (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .sti_rd    (sti_rd),
    .sti_addr  (sti_addr),
    .bit_sel   (bit_sel),
    .res_rd    (res_rd),
    .res_wr    (res_wr),
    .res_addr  (res_addr),
    .pass      (pass),
    .border    (border),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic applyStimulus(input bit s, input bit r);
    start     = s;
    pix_ready = r;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_back = 0; m_rdcyc = 0; m_done = 0; m_pix = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_back = 0; m_rdcyc = 0; m_done = 0; m_pix = 0;
      end
    end else if (m_rdcyc) begin
      m_rdcyc = 0;
    end else if (pix_ready) begin
      if (!m_back) begin
        if (m_pix == NPIX - 1) begin
          m_back  = 1;
          m_rdcyc = 1;
        end else begin
          m_pix++;
        end
      end else if (m_pix == 0) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_pix--;
        m_rdcyc = 1;
      end
    end
    #1;
    e_row = m_pix / W;
    e_col = m_pix % W;
    checkOutput("busy",      busy,      m_active);
    checkOutput("done",      done,      m_done);
    checkOutput("sti_rd",    sti_rd,    m_active);
    checkOutput("res_rd",    res_rd,    m_active && m_rdcyc);
    checkOutput("res_wr",    res_wr,    m_active && !m_rdcyc);
    checkOutput("pix_valid", pix_valid, m_active && !m_rdcyc);
    checkOutput("pass",      pass,      m_active && m_back);
    checkOutput("res_addr",  res_addr,  m_active ? m_pix : 0);
    checkOutput("sti_addr",  sti_addr,  m_active ? m_pix / 16 : 0);
    checkOutput("bit_sel",   bit_sel,   m_active ? 15 - (m_pix % 16) : 0);
    checkOutput("border",    border,
                m_active && (e_row == 0 || e_row == H - 1 || e_col == 0 || e_col == W - 1));
    if (m_active && !m_back) begin
      if (m_pix == 17) begin
        checkOutput("sti_addr_at17", sti_addr, 1);
        checkOutput("bit_sel_at17",  bit_sel,  14);
      end
      if (m_pix == 16383) begin
        checkOutput("sti_addr_at16383", sti_addr, 1023);
        checkOutput("bit_sel_at16383",  bit_sel,  0);
      end
      if (m_pix inside {0, 127, 128, 255, 16256, 16383})
        checkOutput("border_edge_pixel", border, 1);
      if (m_pix inside {129, 8000})
        checkOutput("border_inner_pixel", border, 0);
    end
  end

  initial begin
    int cyc;
    int guard;
    reset     = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {busy, done, sti_rd, res_rd, res_wr, pass, border, pix_valid,
                 sti_addr, bit_sel, res_addr}, 0);
    reset = 1'b0;

    $display("[TB] reset in the middle of the forward pass");
    applyStimulus(1, 1);
    guard = 0;
    while (res_addr != 14'd300 && guard < 1000) begin
      applyStimulus(0, 1);
      guard++;
    end
    if (guard >= 1000) timeoutFail("reach_idx300");
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_outputs",
                {busy, done, sti_rd, res_rd, res_wr, pass, border, pix_valid,
                 sti_addr, bit_sel, res_addr}, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] full job with pix_ready held high");
    applyStimulus(1, 1);
    checkOutput("restart_addr", res_addr, 0);
    checkOutput("restart_wr",   res_wr,   1);
    cyc = 1;
    while (!done && cyc < 60000) begin
      applyStimulus(cyc == 5000, 1);
      cyc++;
    end
    checkOutput("done_cycle", cyc,  49153);
    checkOutput("done_level", done, 1);
    checkOutput("done_busy",  busy, 0);

    $display("[TB] restart from done with random ready and a backward stall");
    applyStimulus(1, 1);
    checkOutput("restart_done",  done,     0);
    checkOutput("restart_pass",  pass,     0);
    checkOutput("restart_addr2", res_addr, 0);
    guard = 0;
    while (!res_rd && guard < 40000) begin
      applyStimulus(1'($urandom_range(0, 15) == 0),
                    (guard < 1500) ? 1'($urandom_range(0, 3) != 0) : 1'b1);
      guard++;
    end
    if (guard >= 40000) timeoutFail("reach_backward");
    guard = 0;
    while (!(pix_valid && pass && res_addr == 14'd5000) && guard < 40000) begin
      applyStimulus(1'($urandom_range(0, 15) == 0),
                    (guard < 600) ? 1'($urandom_range(0, 1)) : 1'b1);
      guard++;
    end
    if (guard >= 40000) timeoutFail("reach_bwr5000");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0);
      checkOutput("stall_addr",  res_addr,  5000);
      checkOutput("stall_wr",    res_wr,    1);
      checkOutput("stall_valid", pix_valid, 1);
    end
    applyStimulus(0, 1);
    checkOutput("post_stall_rd",   res_rd,   1);
    checkOutput("post_stall_addr", res_addr, 4999);
    repeat (20) applyStimulus(0, 1);

    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("final_reset_outputs",
                {busy, done, sti_rd, res_rd, res_wr, pass, border, pix_valid,
                 sti_addr, bit_sel, res_addr}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) applyStimulus(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
